jtframe_vtgen: RTL and testbench

Video timing generator placed directly upstream of the sync repositioning stage. It counts pixels and lines on the pixel clock enable and produces the raster position plus the blanking and sync signals that stage consumes: LHBL, LVBL, HS, VS, and a field toggle. All timing points are parameters, so one block covers every core's native raster. All outputs are registered and consistent with each other at every clock.

---
 rtl/jtframe_vtgen.sv | 146 ++++++++++++++
 tb/tb_jtframe_vtgen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_vtgen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jtframe_vtgen                                                 |
// | Purpose  : Parameterised video timing generator. Counts pixels and lines |
// |            on the pixel clock enable and produces the raster position    |
// |            with blanking, sync, line/frame start strobes and a field     |
// |            toggle, all registered and mutually consistent every clock.   |
// | Ports    : clk, rst (async, active-high), pxl_cen (pixel enable)         |
// |            hcnt/vcnt  current pixel / line count (CNTW bits)             |
// |            LHBL/LVBL  high while horizontally / vertically active        |
// |            HS/VS      active-high syncs                                  |
// |            hinit      high while hcnt==0                                 |
// |            vinit      high while hcnt==0 and vcnt==0                     |
// |            field      toggles once per frame                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module jtframe_vtgen #(
  parameter int CNTW     = 10,
  parameter int HCNT_END = 383,
  parameter int HB_START = 256,
  parameter int HB_END   = 0,
  parameter int HS_START = 296,
  parameter int HS_END   = 328,
  parameter int VCNT_END = 261,
  parameter int VB_START = 240,
  parameter int VB_END   = 16,
  parameter int VS_START = 244,
  parameter int VS_END   = 247,
  parameter int VS_HPOS  = 296
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pxl_cen,
  output logic [CNTW-1:0] hcnt,
  output logic [CNTW-1:0] vcnt,
  output logic            LHBL,
  output logic            LVBL,
  output logic            HS,
  output logic            VS,
  output logic            hinit,
  output logic            vinit,
  output logic            field
);

  localparam logic [CNTW-1:0] c_one      = CNTW'(1);
  localparam logic [CNTW-1:0] c_hcnt_end = CNTW'(HCNT_END);
  localparam logic [CNTW-1:0] c_hb_start = CNTW'(HB_START);
  localparam logic [CNTW-1:0] c_hb_end   = CNTW'(HB_END);
  localparam logic [CNTW-1:0] c_hs_start = CNTW'(HS_START);
  localparam logic [CNTW-1:0] c_hs_end   = CNTW'(HS_END);
  localparam logic [CNTW-1:0] c_vcnt_end = CNTW'(VCNT_END);
  localparam logic [CNTW-1:0] c_vb_start = CNTW'(VB_START);
  localparam logic [CNTW-1:0] c_vb_end   = CNTW'(VB_END);
  localparam logic [CNTW-1:0] c_vs_start = CNTW'(VS_START);
  localparam logic [CNTW-1:0] c_vs_end   = CNTW'(VS_END);
  localparam logic [CNTW-1:0] c_vs_hpos  = CNTW'(VS_HPOS);

  // Decoded outputs at raster position (0,0), loaded while in reset so the
  // outputs agree with the counters from the very first clock.
  localparam logic c_lhbl_rst = (HB_END == 0) && (HB_START > 0);
  localparam logic c_lvbl_rst = (VB_END == 0) && (VB_START > 0);
  localparam logic c_hs_rst   = (HS_START == 0) && (HS_END > 0);
  localparam logic c_vs_rst   = (VS_START == 0) && (VS_HPOS == 0) && (VS_END > 0);

`ifndef SYNTHESIS
  if (!(HCNT_END < (1 << CNTW) && VCNT_END < (1 << CNTW) &&
        HB_START < (1 << CNTW) && HS_END < (1 << CNTW) &&
        VB_START < (1 << CNTW) && VS_HPOS < (1 << CNTW) &&
        HB_END <= HB_START && VB_END <= VB_START &&
        HS_START < HS_END && HS_END <= HCNT_END + 1 &&
        VS_START < VS_END && VS_END <= VCNT_END)) begin : g_param_check
    $error("jtframe_vtgen: illegal timing parameters");
  end
`endif

  // Half-open unsigned interval test [lo, hi).
  function automatic logic in_range(input logic [CNTW-1:0] x,
                                    input logic [CNTW-1:0] lo,
                                    input logic [CNTW-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

  // Raster-order comparison (v,h) >= (vr,hr).
  function automatic logic raster_ge(input logic [CNTW-1:0] v,
                                     input logic [CNTW-1:0] h,
                                     input logic [CNTW-1:0] vr,
                                     input logic [CNTW-1:0] hr);
    return (v > vr) || ((v == vr) && (h >= hr));
  endfunction

  logic [CNTW-1:0] r_hcnt, r_vcnt;
  logic            r_lhbl, r_lvbl, r_hs, r_vs, r_hinit, r_vinit, r_field;

  logic            w_hwrap, w_vwrap;
  logic [CNTW-1:0] w_hnext, w_vnext;
  logic            w_lhbl, w_lvbl, w_hs, w_vs;

  assign w_hwrap = (r_hcnt == c_hcnt_end);
  assign w_vwrap = (r_vcnt == c_vcnt_end);
  assign w_hnext = w_hwrap ? '0 : r_hcnt + c_one;
  assign w_vnext = !w_hwrap ? r_vcnt : (w_vwrap ? '0 : r_vcnt + c_one);

  // Decode is taken from the next counter values so the registered flags
  // land on the same edge as the counters they describe.
  assign w_lhbl = in_range(w_hnext, c_hb_end, c_hb_start);
  assign w_lvbl = in_range(w_vnext, c_vb_end, c_vb_start);
  assign w_hs   = in_range(w_hnext, c_hs_start, c_hs_end);
  assign w_vs   = raster_ge(w_vnext, w_hnext, c_vs_start, c_vs_hpos) &&
                  !raster_ge(w_vnext, w_hnext, c_vs_end, c_vs_hpos);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt  <= '0;
      r_vcnt  <= '0;
      r_lhbl  <= c_lhbl_rst;
      r_lvbl  <= c_lvbl_rst;
      r_hs    <= c_hs_rst;
      r_vs    <= c_vs_rst;
      r_hinit <= 1'b1;
      r_vinit <= 1'b1;
      r_field <= 1'b0;
    end else if (pxl_cen) begin
      r_hcnt  <= w_hnext;
      r_vcnt  <= w_vnext;
      r_lhbl  <= w_lhbl;
      r_lvbl  <= w_lvbl;
      r_hs    <= w_hs;
      r_vs    <= w_vs;
      r_hinit <= (w_hnext == '0);
      r_vinit <= (w_hnext == '0) && (w_vnext == '0);
      r_field <= r_field ^ (w_hwrap && w_vwrap);
    end
  end

  assign hcnt  = r_hcnt;
  assign vcnt  = r_vcnt;
  assign LHBL  = r_lhbl;
  assign LVBL  = r_lvbl;
  assign HS    = r_hs;
  assign VS    = r_vs;
  assign hinit = r_hinit;
  assign vinit = r_vinit;
  assign field = r_field;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_vtgen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_jtframe_vtgen                                              |
// | Purpose  : Self-checking bench for jtframe_vtgen. Three instances run in |
// |            lock-step: default raster, a wide-line raster and a small     |
// |            raster short enough to cover whole frames. A reference model  |
// |            pushes expected outputs per pixel pulse; monitors check line/ |
// |            frame lengths, sync widths and edge positions.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_jtframe_vtgen;

  localparam int N = 3;
  // instance parameters: default, wide line, small raster
  localparam int P_HEND[N] = '{383, 511, 47};
  localparam int P_HBS [N] = '{256, 448, 32};
  localparam int P_HBE [N] = '{0,   64,  4};
  localparam int P_HSS [N] = '{296, 470, 36};
  localparam int P_HSE [N] = '{328, 502, 40};
  localparam int P_VEND[N] = '{261, 223, 19};
  localparam int P_VBS [N] = '{240, 208, 16};
  localparam int P_VBE [N] = '{16,  16,  2};
  localparam int P_VSS [N] = '{244, 212, 17};
  localparam int P_VSE [N] = '{247, 215, 19};
  localparam int P_VSH [N] = '{296, 470, 36};
  // derived raster figures
  localparam int D_LINE [N] = '{384, 512, 48};
  localparam int D_HSW  [N] = '{32, 32, 4};
  localparam int D_HACT [N] = '{256, 384, 28};
  localparam int D_FRAME[N] = '{100608, 114688, 960};
  localparam int D_VSW  [N] = '{1152, 1536, 96};

  logic clk = 1'b0;
  logic rst;
  logic pxl_cen;
  always #5 clk = ~clk;

  logic [9:0] hc[N], vc[N];
  logic lhbl[N], lvbl[N], hs[N], vs[N], hini[N], vini[N], fld[N];
  logic [26:0] got[N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign got[g] = {hc[g], vc[g], lhbl[g], lvbl[g], hs[g], vs[g], hini[g], vini[g], fld[g]};
  end

  jtframe_vtgen u_def (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
    .hcnt(hc[0]), .vcnt(vc[0]), .LHBL(lhbl[0]), .LVBL(lvbl[0]),
    .HS(hs[0]), .VS(vs[0]), .hinit(hini[0]), .vinit(vini[0]), .field(fld[0])
  );

  jtframe_vtgen #(
    .CNTW(10), .HCNT_END(P_HEND[1]), .HB_START(P_HBS[1]), .HB_END(P_HBE[1]),
    .HS_START(P_HSS[1]), .HS_END(P_HSE[1]), .VCNT_END(P_VEND[1]),
    .VB_START(P_VBS[1]), .VB_END(P_VBE[1]), .VS_START(P_VSS[1]),
    .VS_END(P_VSE[1]), .VS_HPOS(P_VSH[1])
  ) u_wide (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
    .hcnt(hc[1]), .vcnt(vc[1]), .LHBL(lhbl[1]), .LVBL(lvbl[1]),
    .HS(hs[1]), .VS(vs[1]), .hinit(hini[1]), .vinit(vini[1]), .field(fld[1])
  );

  jtframe_vtgen #(
    .CNTW(10), .HCNT_END(P_HEND[2]), .HB_START(P_HBS[2]), .HB_END(P_HBE[2]),
    .HS_START(P_HSS[2]), .HS_END(P_HSE[2]), .VCNT_END(P_VEND[2]),
    .VB_START(P_VBS[2]), .VB_END(P_VBE[2]), .VS_START(P_VSS[2]),
    .VS_END(P_VSE[2]), .VS_HPOS(P_VSH[2])
  ) u_small (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
    .hcnt(hc[2]), .vcnt(vc[2]), .LHBL(lhbl[2]), .LVBL(lvbl[2]),
    .HS(hs[2]), .VS(vs[2]), .hinit(hini[2]), .vinit(vini[2]), .field(fld[2])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int mh[N], mv[N];
  bit mf[N];

  function automatic logic [26:0] expect_out(int i, int h, int v, bit f);
    logic l_lhbl, l_lvbl, l_hs, l_vs, l_on, l_off;
    l_lhbl = (h >= P_HBE[i]) && (h < P_HBS[i]);
    l_lvbl = (v >= P_VBE[i]) && (v < P_VBS[i]);
    l_hs   = (h >= P_HSS[i]) && (h < P_HSE[i]);
    l_on   = (v > P_VSS[i]) || ((v == P_VSS[i]) && (h >= P_VSH[i]));
    l_off  = (v > P_VSE[i]) || ((v == P_VSE[i]) && (h >= P_VSH[i]));
    l_vs   = l_on && !l_off;
    return {10'(h), 10'(v), l_lhbl, l_lvbl, l_hs, l_vs, (h == 0), (h == 0) && (v == 0), f};
  endfunction

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (mh[i] == P_HEND[i]) begin
        mh[i] = 0;
        if (mv[i] == P_VEND[i]) begin
          mv[i] = 0;
          mf[i] = ~mf[i];
        end else mv[i]++;
      end else mh[i]++;
    end
  endtask

  // ---------------- monitors ----------------
  int cnt_h[N], cnt_v[N], hs_cnt[N], hb_cnt[N], vs_cnt[N];
  logic [26:0] prev[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mh[i] = 0; mv[i] = 0; mf[i] = 1'b0;
      cnt_h[i] = 0; cnt_v[i] = 0; hs_cnt[i] = 0; hb_cnt[i] = 0; vs_cnt[i] = 0;
      prev[i] = expect_out(i, 0, 0, 1'b0);
    end
  endtask

  task automatic monitor(int i);
    logic [26:0] c, p;
    int h, v, pv;
    c = got[i];
    p = prev[i];
    h = int'(c[26:17]);
    v = int'(c[16:7]);
    pv = int'(p[16:7]);
    cnt_h[i]++; cnt_v[i]++;
    if (c[4]) hs_cnt[i]++;
    if (c[6]) hb_cnt[i]++;
    if (c[3]) vs_cnt[i]++;
    if (c[2] && !p[2]) begin
      check($sformatf("line_len%0d", i), cnt_h[i], D_LINE[i]);
      check($sformatf("hs_width%0d", i), hs_cnt[i], D_HSW[i]);
      check($sformatf("lhbl_active%0d", i), hb_cnt[i], D_HACT[i]);
      cnt_h[i] = 0; hs_cnt[i] = 0; hb_cnt[i] = 0;
    end
    if (c[1] && !p[1]) begin
      check($sformatf("frame_len%0d", i), cnt_v[i], D_FRAME[i]);
      check($sformatf("vs_width%0d", i), vs_cnt[i], D_VSW[i]);
      cnt_v[i] = 0; vs_cnt[i] = 0;
    end
    if (c[6] != p[6])
      check($sformatf("lhbl_edge%0d", i), h, c[6] ? P_HBE[i] : P_HBS[i]);
    if (c[4] != p[4])
      check($sformatf("hs_edge%0d", i), h, c[4] ? P_HSS[i] : P_HSE[i]);
    if (c[5] != p[5]) begin
      check($sformatf("lvbl_edge_h%0d", i), h, 0);
      check($sformatf("lvbl_edge_v%0d", i), v, c[5] ? P_VBE[i] : P_VBS[i]);
    end
    if (c[3] != p[3]) begin
      check($sformatf("vs_edge_h%0d", i), h, P_VSH[i]);
      check($sformatf("vs_edge_v%0d", i), v, c[3] ? P_VSS[i] : P_VSE[i]);
    end
    if (c[0] != p[0]) begin
      check($sformatf("field_v%0d", i), v, 0);
      check($sformatf("field_pv%0d", i), pv, P_VEND[i]);
    end
    prev[i] = c;
  endtask

  // ---------------- scoreboard ----------------
  typedef logic [N-1:0][26:0] trip_t;
  trip_t sb_q[$];

  // Called at a negedge; one pixel pulse then `gap` idle clocks.
  task automatic pulse(int gap);
    trip_t t;
    pxl_cen = 1'b1;
    model_step();
    for (int i = 0; i < N; i++) t[i] = expect_out(i, mh[i], mv[i], mf[i]);
    sb_q.push_back(t);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      t = sb_q.pop_front();
      for (int i = 0; i < N; i++) begin
        check($sformatf("out%0d", i), 32'(got[i]), 32'(t[i]));
        monitor(i);
      end
    end
    @(negedge clk);
    pxl_cen = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    pxl_cen = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++)
      check($sformatf("por%0d", i), 32'(got[i]), 32'(expect_out(i, 0, 0, 1'b0)));
    check("por_def_flags", 32'(got[0][6:0]), 32'b1000110);
    rst = 1'b0;
    @(negedge clk);

    // pixel enable every 4 clocks
    for (int k = 0; k < 200; k++) pulse(3);

    // asynchronous reset mid-line, mid-frame
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++)
      check($sformatf("async_rst%0d", i), 32'(got[i]), 32'(expect_out(i, 0, 0, 1'b0)));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pxl_cen = (k % 4 == 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        check($sformatf("rst_hold%0d", i), 32'(got[i]), 32'(expect_out(i, 0, 0, 1'b0)));
    end
    @(negedge clk);
    pxl_cen = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    pulse(0);
    check("first_h", 32'(hc[0]), 32'd1);

    // irregular enable spacing, covering two small-raster frames
    for (int k = 0; k < 2100; k++) pulse(int'($urandom_range(0, 2)));

    // enable held low: everything frozen
    repeat (1000) @(negedge clk);
    for (int i = 0; i < N; i++)
      check($sformatf("freeze%0d", i), 32'(got[i]), 32'(expect_out(i, mh[i], mv[i], mf[i])));
    for (int k = 0; k < 5; k++) pulse(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
